// File: rtl/clock_pkg.sv
// Shared BCD types and field limits for the CLOCK design.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  localparam bcd_pair_t SEC_MAX  = 8'h59;
  localparam bcd_pair_t MIN_MAX  = 8'h59;
  localparam bcd_pair_t HR24_MAX = 8'h23;
  localparam bcd_pair_t HR12_MAX = 8'h12;

  // Two-digit BCD +1 with no range limiting; callers handle wrap.
  function automatic bcd_pair_t bcd_inc(input bcd_pair_t v);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      units = 4'd0;
      tens  = tens + 4'd1;
    end else begin
      units = units + 4'd1;
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter, MIN_VAL..MAX_VAL; clr loads RST_VAL, carry flags the wrap.
module bcd2_counter
  import clock_pkg::*;
#(
  parameter bcd_pair_t MAX_VAL = SEC_MAX,
  parameter bcd_pair_t MIN_VAL = 8'h00,
  parameter bcd_pair_t RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       carry
);

  bcd_pair_t q_q;
  bcd_pair_t q_d;

  always_comb begin
    q_d   = q_q;
    carry = inc && (q_q == MAX_VAL);
    if (clr) begin
      q_d = RST_VAL;
    end else if (inc) begin
      q_d = (q_q == MAX_VAL) ? MIN_VAL : bcd_inc(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= RST_VAL;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/hms_time_counter.sv
// BCD hh:mm:ss timekeeper with prescaler, adjust pulses and event strobes.
// HMS_12H_EN selects the 12-hour build with a pm flag; default is 24-hour.
module hms_time_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PW            = $clog2(TICKS_PER_SEC)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clr,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hr,
  output logic       pm,
  output logic       sec_pulse,
  output logic       day_wrap
);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

`ifdef HMS_12H_EN
  localparam bcd_pair_t HR_MAX = HR12_MAX;
  localparam bcd_pair_t HR_MIN = 8'h01;
  localparam bcd_pair_t HR_RST = 8'h12;
`else
  localparam bcd_pair_t HR_MAX = HR24_MAX;
  localparam bcd_pair_t HR_MIN = 8'h00;
  localparam bcd_pair_t HR_RST = 8'h00;
`endif

  logic [PW-1:0] presc_q, presc_d;
  logic          sec_pulse_q, sec_pulse_d;
  logic          day_wrap_q, day_wrap_d;
  logic          at_term, adj, tick;
  logic          sec_inc, min_inc, hr_inc;
  logic          sec_carry, min_carry, hr_carry;

  // An adjust in the terminal cycle blocks the tick; the prescaler then
  // stays at terminal so the second lands on the next adjust-free edge.
  always_comb begin
    at_term = run && (presc_q == PRESC_LAST);
    adj     = inc_min || inc_hr;
    tick    = !clr && !adj && at_term;

    presc_d = presc_q;
    if (clr || tick)           presc_d = '0;
    else if (run && !at_term)  presc_d = presc_q + 1'b1;

    sec_inc = tick;
    min_inc = (tick && sec_carry) || (!clr && inc_min);
    hr_inc  = (tick && min_carry) || (!clr && inc_hr);

    sec_pulse_d = tick;
  end

  bcd2_counter #(.MAX_VAL(SEC_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .clr(clr), .q(sec), .carry(sec_carry)
  );

  bcd2_counter #(.MAX_VAL(MIN_MAX), .MIN_VAL(8'h00), .RST_VAL(8'h00)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .clr(clr), .q(min), .carry(min_carry)
  );

  bcd2_counter #(.MAX_VAL(HR_MAX), .MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .rst(rst), .inc(hr_inc), .clr(clr), .q(hr), .carry(hr_carry)
  );

`ifdef HMS_12H_EN
  logic pm_q, pm_d;

  // Midnight is the 11->12 step with pm already set, i.e. the step that clears it.
  always_comb begin
    pm_d = pm_q;
    if (clr)                          pm_d = 1'b0;
    else if (hr_inc && hr == 8'h11)   pm_d = !pm_q;
    day_wrap_d = tick && min_carry && (hr == 8'h11) && pm_q && !hr_carry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pm_q <= 1'b0;
    else     pm_q <= pm_d;
  end

  assign pm = pm_q;
`else
  always_comb begin
    day_wrap_d = tick && hr_carry;
  end

  assign pm = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      sec_pulse_q <= 1'b0;
      day_wrap_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_pulse_q <= sec_pulse_d;
      day_wrap_q  <= day_wrap_d;
    end
  end

  assign sec_pulse = sec_pulse_q;
  assign day_wrap  = day_wrap_q;

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter at TICKS_PER_SEC=4.
module tb_hms_time_counter;

`ifdef HMS_12H_EN
  localparam logic [7:0] HR_RST = 8'h12;
`else
  localparam logic [7:0] HR_RST = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst, run, clr, inc_min, inc_hr;
  logic [7:0] sec, min, hr;
  logic       pm, sec_pulse, day_wrap;

  int n_chk = 0;
  int n_err = 0;

  hms_time_counter #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .run(run), .clr(clr), .inc_min(inc_min), .inc_hr(inc_hr),
    .sec(sec), .min(min), .hr(hr), .pm(pm), .sec_pulse(sec_pulse), .day_wrap(day_wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clr();
    run = 1'b0; clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic pulse_hr(input int n);
    repeat (n) begin
      inc_hr = 1'b1; step(1); inc_hr = 1'b0;
    end
  endtask

  task automatic pulse_min(input int n);
    repeat (n) begin
      inc_min = 1'b1; step(1); inc_min = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; clr = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    step(2);
    chk("rst_time", {8'h0, hr, min, sec}, {8'h0, HR_RST, 16'h0000});
    chk("rst_strobes", {29'h0, pm, sec_pulse, day_wrap}, 32'h0);

    // first second after reset
    rst = 1'b0; run = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step(1);
      chk("pre_sec", {23'h0, sec_pulse, sec}, 32'h00);
    end
    step(1);
    chk("first_sec", {23'h0, sec_pulse, sec}, {23'h0, 1'b1, 8'h01});
    step(1);
    chk("pulse_one_cycle", {23'h0, sec_pulse, sec}, {23'h0, 1'b0, 8'h01});

    // inc_min at 10:59:30: no carry into hours
    do_clr();
    pulse_hr(10);
    pulse_min(59);
    run = 1'b1;
    step(120);
    chk("preload_10_59_30", {8'h0, hr, min, sec}, 32'h00105930);
    inc_min = 1'b1; step(1); inc_min = 1'b0;
    chk("inc_min_wrap", {8'h0, hr, min, sec}, 32'h00100030);
    chk("inc_min_no_strobe", {30'h0, sec_pulse, day_wrap}, 32'h0);

    // inc_min during terminal cycle defers the tick
    do_clr();
    run = 1'b1;
    step(20);
    chk("at_00_00_05", {16'h0, min, sec}, 32'h0005);
    step(3);
    inc_min = 1'b1; step(1); inc_min = 1'b0;
    chk("defer_adj", {15'h0, sec_pulse, min, sec}, {15'h0, 1'b0, 16'h0105});
    step(1);
    chk("defer_tick", {15'h0, sec_pulse, min, sec}, {15'h0, 1'b1, 16'h0106});
    step(4);
    chk("no_lost_sec", {24'h0, sec}, 32'h07);

    // run=0 at prescaler=2
    do_clr();
    run = 1'b1;
    step(2);
    run = 1'b0;
    step(10);
    chk("hold_run0", {23'h0, sec_pulse, sec}, 32'h0);
    run = 1'b1;
    step(1);
    chk("resume_1", {23'h0, sec_pulse, sec}, 32'h0);
    step(1);
    chk("resume_2", {23'h0, sec_pulse, sec}, {23'h0, 1'b1, 8'h01});

    // clr beats adjust in the same cycle
    clr = 1'b1; inc_hr = 1'b1; inc_min = 1'b1;
    step(1);
    clr = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    chk("clr_priority", {8'h0, hr, min, sec}, {8'h0, HR_RST, 16'h0000});
    chk("clr_no_strobe", {30'h0, sec_pulse, day_wrap}, 32'h0);

`ifndef HMS_12H_EN
    // midnight wrap from 23:59:58
    do_clr();
    run = 1'b1;
    step(232);
    run = 1'b0;
    pulse_hr(23);
    pulse_min(59);
    chk("preload_23_59_58", {8'h0, hr, min, sec}, 32'h00235958);
    run = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("wrap_day_wrap", {31'h0, day_wrap}, {31'h0, (i == 7)});
      chk("wrap_sec_pulse", {31'h0, sec_pulse}, {31'h0, (i == 3 || i == 7)});
      if (i == 3) chk("wrap_23_59_59", {8'h0, hr, min, sec}, 32'h00235959);
    end
    chk("wrap_00_00_00", {8'h0, hr, min, sec}, 32'h0);
    run = 1'b0;
    pulse_hr(23);
    chk("hr_at_23", {24'h0, hr}, 32'h23);
    inc_hr = 1'b1; step(1); inc_hr = 1'b0;
    chk("inc_hr_wrap", {23'h0, day_wrap, hr}, 32'h0);
`else
    // 12-hour sequence and pm toggle
    do_clr();
    chk("h12_clr", {7'h0, pm, hr, min, sec}, 32'h00120000);
    pulse_hr(11);
    chk("h12_at_11", {23'h0, pm, hr}, 32'h011);
    inc_hr = 1'b1; step(1); inc_hr = 1'b0;
    chk("h12_pm_set", {23'h0, pm, hr}, {23'h0, 1'b1, 8'h12});
    chk("h12_no_wrap", {31'h0, day_wrap}, 32'h0);
    run = 1'b1;
    step(6);
    #2;
    rst = 1'b1;
    #1;
    chk("h12_async_rst", {7'h0, pm, hr, min, sec}, 32'h00120000);
    step(1);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
